// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request after last_i,
// wrapping modulo N_REQ, returned as one-hot grant and index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  localparam int unsigned NR = N_REQ;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] elig_sh;
  int unsigned      cand;

  assign elig = req_i & mask_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    elig_sh = '0;
    // k = NR wraps back onto last_i itself, so it is searched last
    for (int unsigned k = 1; k <= NR; k++) begin
      cand    = (32'(last_i) + k) % NR;
      elig_sh = elig >> cand;
      if (!any_o && elig_sh[0]) begin
        any_o   = 1'b1;
        grant_o = N_REQ'(1) << cand;
        idx_o   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Define UART_ARB_FRAME_LOCK_EN to hold the grant on one requester until req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         active
);

  arb_state_e             state_q, state_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [N_REQ-1:0]       mask;
  logic [N_REQ-1:0]       pick_gnt;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic                   accept;

`ifdef UART_ARB_FRAME_LOCK_EN
  logic             lock_q, lock_d;
  logic [N_REQ-1:0] last_sh;

  // The lock owner is always the most recently accepted requester
  assign mask    = lock_q ? (N_REQ'(1) << last_q) : '1;
  assign last_sh = req_last >> pick_idx;
  assign lock_d  = accept ? ~last_sh[0] : lock_q;

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  logic unused_last;

  assign mask        = '1;
  assign unused_last = ^req_last;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .mask_i  (mask),
    .last_i  (last_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept    = (state_q == IDLE) && !tx_busy && pick_any;
  assign req_ready = accept ? pick_gnt : '0;
  assign tx_start  = (state_q == LAUNCH);
  assign active    = (state_q != IDLE);
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = LAUNCH;
          tx_data_d  = UART_BYTE_W'(req_data >> (32'(pick_idx) * UART_BYTE_W));
          grant_id_d = pick_idx;
          last_d     = pick_idx;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      last_q     <= ID_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx (divider 4) and a scoreboard.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start, tx_busy, active;
  logic [7:0]     tx_data;
  logic [IDW-1:0] grant_id;
  logic           ext_busy = 1'b0;

  logic           mdl_busy, txd;
  logic [9:0]     sh;
  int unsigned    divc, bitc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;

  typedef struct {
    bit             rst_before;
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [IDW-1:0] exp_id;
    logic [7:0]     exp_data;
    string          name;
  } vec_t;

  exp_t q_start[$];
  exp_t q_ser[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign tx_busy = mdl_busy | ext_busy;

  uart_tx_arbiter #(
    .N_REQ (N),
    .ID_W  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  // uart_tx stand-in: busy the cycle after tx_start, 10 bits of DIV cycles each
  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      txd      <= 1'b1;
      sh       <= '1;
      divc     <= 0;
      bitc     <= 0;
    end else if (!mdl_busy && tx_start) begin
      mdl_busy <= 1'b1;
      sh       <= {1'b1, tx_data, 1'b0};
      txd      <= 1'b0;
      divc     <= 0;
      bitc     <= 0;
    end else if (mdl_busy) begin
      if (divc == DIV - 1) begin
        divc <= 0;
        if (bitc == 9) begin
          mdl_busy <= 1'b0;
          txd      <= 1'b1;
        end else begin
          bitc <= bitc + 1;
          sh   <= sh >> 1;
          txd  <= sh[1];
        end
      end else begin
        divc <= divc + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*N-1:0] pack4(input logic [7:0] d3, input logic [7:0] d2,
                                           input logic [7:0] d1, input logic [7:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input bit r, input logic [N-1:0] v, input logic [8*N-1:0] d,
                              input logic [N-1:0] l, input logic [IDW-1:0] id,
                              input logic [7:0] b, input string nm);
    vec_t t;
    t.rst_before = r;
    t.valid      = v;
    t.data       = d;
    t.last       = l;
    t.exp_id     = id;
    t.exp_data   = b;
    t.name       = nm;
    return t;
  endfunction

  exp_t st_e;
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      if (q_start.size() == 0) begin
        check("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        st_e = q_start.pop_front();
        check("grant_id", 32'(grant_id), 32'(st_e.id));
        check("tx_data_at_start", 32'(tx_data), 32'(st_e.data));
        check("active_in_launch", 32'(active), 32'd1);
      end
    end
  end

  exp_t       se;
  logic       prev_busy = 1'b0;
  bit         in_frame  = 1'b0;
  int         ser_cnt   = 0;
  logic [9:0] bits      = '0;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      q_ser.delete();
    end else begin
      if (mdl_busy && !prev_busy) begin
        in_frame = 1'b1;
        ser_cnt  = 0;
      end
      if (in_frame) begin
        if (ser_cnt % DIV == 1) bits[ser_cnt / DIV] = txd;
        if (ser_cnt == 9 * DIV + 1) begin
          in_frame = 1'b0;
          if (q_ser.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            se = q_ser.pop_front();
            check("serial_frame", 32'(bits), 32'({1'b1, se.data, 1'b0}));
            check("tx_data_hold", 32'(tx_data), 32'(se.data));
          end
        end
        ser_cnt++;
      end
    end
    prev_busy = mdl_busy;
  end

  task automatic push_exp(input logic [IDW-1:0] id, input logic [7:0] b);
    q_start.push_back(exp_t'{id, b});
    q_ser.push_back(exp_t'{id, b});
  endtask

  task automatic do_reset();
    int unsigned w = 0;
    req_valid = '0;
    while ((q_start.size() != 0 || q_ser.size() != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drained_before_reset", 32'(q_start.size() + q_ser.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned w = 0;
    if (v.rst_before) do_reset();
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    #1;
    while (req_ready == '0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (req_ready == '0) begin
      check({v.name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({v.name, "_ready"}, 32'(req_ready), 32'(N'(1) << v.exp_id));
    push_exp(v.exp_id, v.exp_data);
    @(negedge clk);
    #1;
    check({v.name, "_ready_drop"}, 32'(req_ready), 32'd0);
    check({v.name, "_start"}, 32'(tx_start), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int unsigned w;

    vecs.push_back(mk(1, 4'b0100, pack4(8'h00, 8'hA5, 8'h00, 8'h00), 4'b0000, 2, 8'hA5, "single_a5"));
    vecs.push_back(mk(1, 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0000, 0, 8'h10, "rr0"));
    vecs.push_back(mk(0, 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0000, 1, 8'h11, "rr1"));
    vecs.push_back(mk(0, 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0000, 2, 8'h12, "rr2"));
    vecs.push_back(mk(0, 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0000, 3, 8'h13, "rr3"));
    vecs.push_back(mk(0, 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0000, 0, 8'h10, "rr4"));
    // Prime the pointer to 2 so requester 3 is next in line
    vecs.push_back(mk(1, 4'b0100, pack4(8'h00, 8'h22, 8'h00, 8'h00), 4'b0000, 2, 8'h22, "fl_prime"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h01, 8'h00, 8'h00, 8'h70), 4'b0000, 3, 8'h01, "fl_a"));
`ifdef UART_ARB_FRAME_LOCK_EN
    vecs.push_back(mk(0, 4'b1001, pack4(8'h02, 8'h00, 8'h00, 8'h70), 4'b0000, 3, 8'h02, "fl_b"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h03, 8'h00, 8'h00, 8'h70), 4'b1000, 3, 8'h03, "fl_c"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h03, 8'h00, 8'h00, 8'h70), 4'b0000, 0, 8'h70, "fl_d"));
`else
    vecs.push_back(mk(0, 4'b1001, pack4(8'h02, 8'h00, 8'h00, 8'h70), 4'b0000, 0, 8'h70, "fl_b"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h02, 8'h00, 8'h00, 8'h70), 4'b0000, 3, 8'h02, "fl_c"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h03, 8'h00, 8'h00, 8'h70), 4'b1000, 0, 8'h70, "fl_d"));
    vecs.push_back(mk(0, 4'b1001, pack4(8'h03, 8'h00, 8'h00, 8'h70), 4'b1000, 3, 8'h03, "fl_e"));
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
    req_valid = '0;

    // External busy must hold off the grant until it falls
    do_reset();
    ext_busy  = 1'b1;
    req_valid = 4'b0010;
    req_data  = pack4(8'h00, 8'h00, 8'h55, 8'h00);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (req_ready != '0 || active) ok = 1'b0;
    end
    check("busy_hold_off", 32'(ok), 32'd1);
    ext_busy = 1'b0;
    #1;
    check("grant_after_busy", 32'(req_ready), 32'b0010);
    push_exp(1, 8'h55);
    @(negedge clk);
    req_valid = '0;

    // Reset while waiting for busy to fall
    run_vec(mk(1, 4'b0010, pack4(8'h00, 8'h00, 8'h3C, 8'h00), 4'b0000, 1, 8'h3C, "abort_3c"));
    req_valid = '0;
    repeat (12) @(negedge clk);
    #1;
    check("abort_in_flight", 32'({active, tx_busy, grant_id}), 32'({1'b1, 1'b1, 2'd1}));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_tx_start", 32'(tx_start), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_grant_id", 32'(grant_id), 32'd0);
    check("abort_active", 32'(active), 32'd0);
    check("abort_tx_idle", 32'(txd), 32'd1);
    rst = 1'b0;
    run_vec(mk(0, 4'b1111, pack4(8'h44, 8'h33, 8'h22, 8'h11), 4'b0000, 0, 8'h11, "post_abort"));
    req_valid = '0;

    w = 0;
    while ((q_start.size() != 0 || q_ser.size() != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", 32'(q_start.size() + q_ser.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `N_REQ` byte producers. Each requester offers a byte with a valid/ready handshake. The arbiter accepts one byte at a time, launches it into `uart_tx` with a one-cycle `tx_start` pulse, and holds off further grants until `uart_tx` deasserts `busy`. It sits between the system's message sources (debug, status, command echo) and the single UART pin.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `ID_W`, default 2: width of `grant_id`; must be ≥ clog2(`N_REQ`).
- `clk` input 1: system clock (50 MHz in the reference system).
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input `N_REQ`: requester i offers a byte.
- `req_data` input 8×`N_REQ`: byte i occupies bits [8i+7:8i].
- `req_last` input `N_REQ`: marks the offered byte as the last byte of a frame. Used only with `UART_ARB_FRAME_LOCK_EN`.
- `req_ready` output `N_REQ`: one-hot acceptance strobe; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_start` output 1: one-cycle launch pulse to `uart_tx`.
- `tx_data` output 8: byte to `uart_tx.data_in`; stable from `tx_start` until `busy` falls.
- `tx_busy` input 1: `busy` from `uart_tx`.
- `grant_id` output `ID_W`: index of the requester whose byte is in flight.
- `active` output 1: high in every state except IDLE.

## Operation
- FSM states:
  - **IDLE.** If any eligible `req_valid` is high and `tx_busy` is 0, select a winner, drive `req_ready[winner]`=1 (combinational, this cycle), register `tx_data` and `grant_id`, then go to LAUNCH.
  - **LAUNCH.** `tx_start`=1 for exactly this cycle; go to WAIT_BUSY.
  - **WAIT_BUSY.** Wait for `tx_busy`=1, then go to WAIT_DONE.
  - **WAIT_DONE.** Wait for `tx_busy`=0, then go to IDLE.
- `req_ready` is all-zero outside IDLE. At most one bit is ever set.
- Round-robin selection:
  - Pointer `last` holds the most recently accepted index.
  - Search starts at `last`+1 modulo `N_REQ` and takes the first valid requester.
  - `last` updates only on an accepted transfer.
- Requesters may change `req_data` or drop `req_valid` without penalty while not accepted; no stability is required before acceptance.
- `tx_data` and `grant_id` hold their value until the next acceptance.
- Reset values: state=IDLE, `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `grant_id`=0, `active`=0, `last`=`N_REQ`-1 so requester 0 wins first. Frame lock is cleared.
- Reset mid-transfer: everything returns to reset values on the next edge. `uart_tx` shares `rst`, so no byte is resumed.
- If `tx_busy` is already 1 in IDLE (external use or an aborted state), no grant is made until it falls.

## Timing
- Acceptance in cycle T: `tx_start`=1 in T+1.
- `uart_tx` asserts `busy` in T+2.
- Next acceptance is possible no earlier than the cycle after `busy` falls, plus one IDLE cycle.
- Per-byte overhead: 3 cycles beyond the `uart_tx` frame time of 10×`BAUD_RATE_DIV` cycles.
- Simultaneous valids: exactly one is granted; the others wait. No requester waits more than `N_REQ`-1 bytes when all are continuously valid (without frame lock).

## Configuration
- `UART_ARB_FRAME_LOCK_EN` defined:
  - An accepted byte with `req_last`=0 locks arbitration to that requester.
  - While locked, only that requester is eligible. Other valids are ignored even if the owner is idle.
  - The lock clears when the owner's byte with `req_last`=1 is accepted. Reset also clears it.
  - The pointer still updates normally.
- Not defined: `req_last` is ignored, and every byte is arbitrated independently.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE) and the constant `UART_BYTE_W`=8.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are the request vector, the mask and `last`; outputs are a one-hot winner and its index.
- Top-level bench instantiates `uart_tx_arbiter` with `uart_tx` (`BAUD_RATE_DIV` reduced to 4).

## Test plan
- Single request: requester 2 offers 8'hA5 → `req_ready[2]` for one cycle, `tx_start` next cycle, `grant_id`=2, and the serial line shows start bit, 1,0,1,0,0,1,0,1, then stop.
- All four valid continuously with bytes 8'h10..8'h13 → acceptance order 0,1,2,3,0, with no requester granted twice in a row.
- Requester 1 valid, `tx_busy` held 1 externally → no `req_ready` until `busy` falls; grant follows in the next IDLE cycle.
- Reset asserted during WAIT_DONE of byte 8'h3C → next cycle all outputs are at reset values; `tx` idles high; the next grant goes to requester 0.
- `UART_ARB_FRAME_LOCK_EN`: requester 3 sends 8'h01 and 8'h02 (last=0) then 8'h03 (last=1) while requester 0 stays valid → order 3,3,3,0.
- Without the macro, the same stimulus → bytes from requesters 3 and 0 alternate.
